// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris piece-generation logic.
package tetris_pkg;

  typedef logic [2:0] piece_t;

  localparam int unsigned NUM_PIECES = 7;
  localparam logic [NUM_PIECES-1:0] BAG_FULL = 7'h7F;

  typedef enum logic {
    FILL,
    FULL
  } sched_state_t;

endpackage

// File: rtl/lfsr.sv
// 3-bit free-running entropy LFSR; XNOR feedback, period 7 over 0..6 from seed 001.
module lfsr (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] lfsr_o
);

  // XNOR taps lock up only at 111, which the seed never reaches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_o <= 3'b001;
    else       lfsr_o <= {lfsr_o[1:0], ~(lfsr_o[2] ^ lfsr_o[1])};
  end

endmodule

// File: rtl/piece_queue.sv
// In-order shift FIFO of piece codes; entry 0 is the head, unused entries hold 0.
module piece_queue #(
  parameter int DEPTH = 3,
  parameter int PW    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  logic [PW-1:0]       din,
  output logic [DEPTH*PW-1:0] contents,
  output logic [2:0]          count
);

  logic [PW-1:0] r_mem [DEPTH];
  logic [PW-1:0] w_next [DEPTH];
  logic [2:0]    r_count;
  logic [2:0]    w_tail;

  // Shift first, then drop the new piece at the post-shift tail so that
  // simultaneous push and pop keep ordering and occupancy.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) w_next[i] = r_mem[i];
    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) w_next[i] = r_mem[i+1];
      w_next[DEPTH-1] = '0;
    end
    w_tail = pop ? r_count - 3'd1 : r_count;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (push && 3'(i) == w_tail) w_next[i] = din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_count <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= w_next[i];
      r_count <= r_count + {2'b0, push} - {2'b0, pop};
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) contents[i*PW +: PW] = r_mem[i];
  end

  assign count = r_count;

endmodule

// File: rtl/piece_scheduler.sv
// 7-bag piece randomizer: rejects LFSR values already issued in the current bag
// and feeds accepted pieces into a preview queue drained by a valid/ready handshake.
module piece_scheduler
  import tetris_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int PW    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                piece_ready,
  output logic                piece_valid,
  output logic [PW-1:0]       piece_o,
  output logic [DEPTH*PW-1:0] preview_o,
  output logic [2:0]          count_o,
  output logic                searching_o
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  sched_state_t          r_state;
  logic [NUM_PIECES-1:0] r_bag;
  logic                  r_valid;

  piece_t                w_lfsr;
  logic                  w_pop;
  logic                  w_can_push;
  logic                  w_used;
  logic                  w_push;
  logic                  w_qpop;
  logic [7:0]            w_onehot;
  logic [NUM_PIECES-1:0] w_bag_set;
  logic [2:0]            w_count_nx;

  lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .lfsr_o (w_lfsr)
  );

  piece_queue #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (w_push),
    .pop      (w_qpop),
    .din      (PW'(w_lfsr)),
    .contents (preview_o),
    .count    (count_o)
  );

  // FULL only blocks the fill engine when nothing leaves the head this edge.
  always_comb begin
    w_pop      = r_valid & piece_ready;
    w_can_push = (r_state == FILL) | w_pop;
    w_onehot   = 8'd1 << w_lfsr;
    w_used     = |({1'b0, r_bag} & w_onehot);
    w_push     = w_can_push & ~w_used & ~flush;
    w_qpop     = w_pop & ~flush;
    w_bag_set  = r_bag | w_onehot[NUM_PIECES-1:0];
    w_count_nx = count_o + {2'b0, w_push} - {2'b0, w_qpop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
      r_bag   <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_state <= FILL;
      r_bag   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) r_bag <= (w_bag_set == BAG_FULL) ? '0 : w_bag_set;
      r_valid <= (w_count_nx != 3'd0);
      r_state <= (w_count_nx == DEPTH_C) ? FULL : FILL;
    end
  end

  assign piece_valid = r_valid;
  assign piece_o     = preview_o[PW-1:0];
  assign searching_o = w_can_push & w_used;

endmodule
